// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants and helpers used by the MEM stage.
package mips_pkg;

  localparam int unsigned WB_REGWRITE = 1;
  localparam int unsigned WB_MEMTOREG = 0;
  localparam int unsigned DMEM_DEPTH  = 256;
  localparam int unsigned DMEM_AW     = 8;

  // An access faults when it is not word aligned, or when it asks to load and store at once.
  function automatic logic access_fault(input logic rd, input logic wr, input logic [1:0] lo);
    return ((rd | wr) && (lo != 2'b00)) || (rd && wr);
  endfunction

endpackage

// File: rtl/mem_stage_data_mem.sv
// Data memory: DMEM_DEPTH x 32-bit words, synchronous write, asynchronous read.
module data_mem
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               we,
  input  logic [DMEM_AW-1:0] addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata
);

  logic [31:0] mem_q [DMEM_DEPTH] = '{default: '0};

  // Word write on the rising edge; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: branch resolution, data memory access with fault
// detection, and the MEM/WB pipeline register.
module mem_stage
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic        zero_i,
  input  logic [31:0] add_result_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] read_data2_i,
  input  logic [4:0]  rd_or_rt_i,
  input  logic [1:0]  wb_i,
  output logic        pc_src_o,
  output logic [31:0] branch_target_o,
  output logic [31:0] mem_data_o,
  output logic [31:0] alu_result_o,
  output logic [4:0]  rd_or_rt_o,
  output logic [1:0]  wb_o,
  output logic        fault_o
);

  logic        fault;
  logic        mem_we;
  logic [31:0] rdata;

  logic [31:0] mem_data_d, mem_data_q;
  logic [31:0] alu_result_d, alu_result_q;
  logic [4:0]  rd_or_rt_d, rd_or_rt_q;
  logic [1:0]  wb_d, wb_q;
  logic        fault_d, fault_q;

  assign pc_src_o        = branch_i & zero_i & ~stall_i;
  assign branch_target_o = add_result_i;

  data_mem u_data_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (alu_result_i[9:2]),
    .wdata (read_data2_i),
    .rdata (rdata)
  );

  // Fault detection, write gating and next-state for the MEM/WB register.
  // The write enable also masks on rst so a store held across reset never lands.
  always_comb begin
    fault        = access_fault(mem_read_i, mem_write_i, alu_result_i[1:0]);
    mem_we       = mem_write_i & ~stall_i & ~fault & ~rst;
    mem_data_d   = '0;
    wb_d         = wb_i;
    fault_d      = fault;
    alu_result_d = alu_result_i;
    rd_or_rt_d   = rd_or_rt_i;
    if (fault) begin
      wb_d = '0;
    end else if (mem_read_i) begin
      mem_data_d = rdata;
    end
  end

  // MEM/WB register: captures when not stalled, clears asynchronously on rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_data_q   <= '0;
      alu_result_q <= '0;
      rd_or_rt_q   <= '0;
      wb_q         <= '0;
      fault_q      <= 1'b0;
    end else if (!stall_i) begin
      mem_data_q   <= mem_data_d;
      alu_result_q <= alu_result_d;
      rd_or_rt_q   <= rd_or_rt_d;
      wb_q         <= wb_d;
      fault_q      <= fault_d;
    end
  end

  assign mem_data_o   = mem_data_q;
  assign alu_result_o = alu_result_q;
  assign rd_or_rt_o   = rd_or_rt_q;
  assign wb_o         = wb_q;
  assign fault_o      = fault_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a word-array reference model.
module tb_mem_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, branch_i, mem_read_i, mem_write_i, zero_i;
  logic [31:0] add_result_i, alu_result_i, read_data2_i;
  logic [4:0]  rd_or_rt_i;
  logic [1:0]  wb_i;
  logic        pc_src_o;
  logic [31:0] branch_target_o, mem_data_o, alu_result_o;
  logic [4:0]  rd_or_rt_o;
  logic [1:0]  wb_o;
  logic        fault_o;

  int tests = 0;
  int fails = 0;

  mem_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .branch_i        (branch_i),
    .mem_read_i      (mem_read_i),
    .mem_write_i     (mem_write_i),
    .zero_i          (zero_i),
    .add_result_i    (add_result_i),
    .alu_result_i    (alu_result_i),
    .read_data2_i    (read_data2_i),
    .rd_or_rt_i      (rd_or_rt_i),
    .wb_i            (wb_i),
    .pc_src_o        (pc_src_o),
    .branch_target_o (branch_target_o),
    .mem_data_o      (mem_data_o),
    .alu_result_o    (alu_result_o),
    .rd_or_rt_o      (rd_or_rt_o),
    .wb_o            (wb_o),
    .fault_o         (fault_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain word array addressed by (byte address mod 1024) / 4.
  logic [31:0] mmem [256];
  logic [31:0] e_data, e_alu;
  logic [4:0]  e_rd;
  logic [1:0]  e_wb;
  logic        e_fault;
  int unsigned m_idx;
  logic        m_bad;

  initial begin
    for (int i = 0; i < 256; i++) mmem[i] = '0;
    e_data = '0; e_alu = '0; e_rd = '0; e_wb = '0; e_fault = 1'b0;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      e_data = '0; e_alu = '0; e_rd = '0; e_wb = '0; e_fault = 1'b0;
    end else if (!stall_i) begin
      m_idx = (alu_result_i % 1024) / 4;
      m_bad = ((mem_read_i || mem_write_i) && (alu_result_i % 4 != 0)) ||
              (mem_read_i && mem_write_i);
      e_alu = alu_result_i;
      e_rd  = rd_or_rt_i;
      if (m_bad) begin
        e_data = '0; e_wb = 2'b00; e_fault = 1'b1;
      end else begin
        e_data  = mem_read_i ? mmem[m_idx] : 32'h0;
        e_wb    = wb_i;
        e_fault = 1'b0;
        if (mem_write_i) mmem[m_idx] = read_data2_i;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    chk("mem_data",   mem_data_o,   e_data);
    chk("alu_result", alu_result_o, e_alu);
    chk("rd_or_rt",   {27'd0, rd_or_rt_o}, {27'd0, e_rd});
    chk("wb",         {30'd0, wb_o},       {30'd0, e_wb});
    chk("fault",      {31'd0, fault_o},    {31'd0, e_fault});
    chk("pc_src",     {31'd0, pc_src_o},   {31'd0, (branch_i & zero_i & ~stall_i)});
    chk("br_target",  branch_target_o, add_result_i);
  end

  // One cycle of stimulus: inputs change 2 time units after a rising edge.
  task automatic drive(input logic st, input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [31:0] wdat,
                       input logic [4:0] dst, input logic [1:0] wb);
    @(posedge clk);
    #2;
    stall_i = st; mem_read_i = rd; mem_write_i = wr;
    alu_result_i = addr; read_data2_i = wdat; rd_or_rt_i = dst; wb_i = wb;
    branch_i = 1'b0; zero_i = 1'b0; add_result_i = '0;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 2'b00);
  endtask

  initial begin
    rst = 1'b1;
    stall_i = 0; branch_i = 0; mem_read_i = 0; mem_write_i = 0; zero_i = 0;
    add_result_i = '0; alu_result_i = '0; read_data2_i = '0; rd_or_rt_i = '0; wb_i = '0;
    #1;
    // Store held on the inputs during reset must not land.
    mem_write_i = 1'b1; alu_result_i = 32'h10; read_data2_i = 32'h5555_5555;
    #1;
    chk("reset_mem_data", mem_data_o, 32'h0);
    chk("reset_wb", {30'd0, wb_o}, 32'h0);
    chk("reset_fault", {31'd0, fault_o}, 32'h0);
    #14;
    mem_write_i = 1'b0; alu_result_i = '0; read_data2_i = '0;
    #1 rst = 1'b0;

    // Load of 0x10 after reset: still zero.
    drive(0, 1, 0, 32'h10, 32'h0, 5'd2, 2'b11);
    idle();
    chk("no_write_in_reset", mem_data_o, 32'h0);

    // Store then load the same word.
    drive(0, 0, 1, 32'h10, 32'hDEAD_BEEF, 5'd0, 2'b00);
    drive(0, 1, 0, 32'h10, 32'h0, 5'd9, 2'b11);
    idle();
    chk("st_ld_data", mem_data_o, 32'hDEAD_BEEF);
    chk("st_ld_wb", {30'd0, wb_o}, {30'd0, 2'b11});
    chk("st_ld_rd", {27'd0, rd_or_rt_o}, 32'd9);
    chk("model_st_ld", e_data, 32'hDEAD_BEEF);

    // Branch, then branch under stall.
    idle();
    branch_i = 1'b1; zero_i = 1'b1; add_result_i = 32'h40;
    #1;
    chk("branch_taken", {31'd0, pc_src_o}, 32'd1);
    chk("branch_target", branch_target_o, 32'h40);
    stall_i = 1'b1;
    #1;
    chk("branch_stalled", {31'd0, pc_src_o}, 32'd0);
    stall_i = 1'b0;

    // Misaligned store faults for one cycle and leaves memory untouched.
    drive(0, 0, 1, 32'h13, 32'h9999_9999, 5'd4, 2'b10);
    drive(0, 1, 0, 32'h10, 32'h0, 5'd5, 2'b11);
    chk("misalign_fault", {31'd0, fault_o}, 32'd1);
    chk("misalign_wb", {30'd0, wb_o}, 32'd0);
    idle();
    chk("fault_pulse_end", {31'd0, fault_o}, 32'd0);
    chk("misalign_no_write", mem_data_o, 32'hDEAD_BEEF);

    // Address wrap at 1 KiB.
    drive(0, 0, 1, 32'h400, 32'h0000_1234, 5'd0, 2'b00);
    drive(0, 1, 0, 32'h000, 32'h0, 5'd1, 2'b11);
    idle();
    chk("wrap_400_to_0", mem_data_o, 32'h0000_1234);
    drive(0, 0, 1, 32'h3FC, 32'hCAFE_F00D, 5'd0, 2'b00);
    drive(0, 1, 0, 32'h7FC, 32'h0, 5'd1, 2'b11);
    idle();
    chk("wrap_3fc_7fc", mem_data_o, 32'hCAFE_F00D);

    // Stall for three cycles with a store on the inputs.
    drive(0, 0, 0, 32'h777, 32'h0, 5'd7, 2'b10);
    drive(1, 0, 1, 32'h20, 32'hAA, 5'd8, 2'b11);
    drive(1, 0, 1, 32'h20, 32'hAA, 5'd8, 2'b11);
    drive(1, 0, 1, 32'h20, 32'hAA, 5'd8, 2'b11);
    drive(0, 1, 0, 32'h20, 32'h0, 5'd6, 2'b11);
    chk("stall_alu_frozen", alu_result_o, 32'h777);
    chk("stall_rd_frozen", {27'd0, rd_or_rt_o}, 32'd7);
    chk("stall_wb_frozen", {30'd0, wb_o}, 32'd2);
    idle();
    chk("stall_no_write", mem_data_o, 32'h0);

    // Simultaneous load and store is a fault.
    drive(0, 1, 1, 32'h20, 32'h1, 5'd3, 2'b11);
    idle();
    chk("rdwr_fault", {31'd0, fault_o}, 32'd1);
    chk("rdwr_wb", {30'd0, wb_o}, 32'd0);

    // Asynchronous reset between edges while wb_o=10.
    drive(0, 0, 0, 32'h5, 32'h0, 5'd3, 2'b10);
    idle();
    chk("pre_reset_wb", {30'd0, wb_o}, 32'd2);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_wb", {30'd0, wb_o}, 32'd0);
    chk("async_rst_alu", alu_result_o, 32'h0);
    chk("async_rst_rd", {27'd0, rd_or_rt_o}, 32'd0);
    chk("async_rst_data", mem_data_o, 32'h0);
    chk("async_rst_fault", {31'd0, fault_o}, 32'd0);
    #2 rst = 1'b0;
    drive(0, 1, 0, 32'h10, 32'h0, 5'd1, 2'b11);
    drive(0, 1, 0, 32'h0, 32'h0, 5'd1, 2'b11);
    chk("retain_0x10", mem_data_o, 32'hDEAD_BEEF);
    idle();
    chk("retain_0x00", mem_data_o, 32'h0000_1234);
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation ran past its time limit");
    $fatal(1);
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock; rst  input  1  asynchronous active-high reset.
REQ-002 The block SHALL have these inputs: stall_i  1  hold stage; branch_i  1  branch control; mem_read_i  1  load; mem_write_i  1  store; zero_i  1  ALU zero flag; add_result_i  32  branch target; alu_result_i  32  byte address or ALU value; read_data2_i  32  store data; rd_or_rt_i  5  destination register; wb_i  2  write-back controls.
REQ-003 The block SHALL have these outputs: pc_src_o  1  take branch; branch_target_o  32  target PC; mem_data_o  32  registered load data; alu_result_o  32  registered ALU value; rd_or_rt_o  5  registered destination; wb_o  2  registered write-back controls; fault_o  1  registered access-fault pulse.
REQ-004 wb_i bit 1 SHALL be RegWrite and bit 0 SHALL be MemtoReg.

Function
REQ-005 pc_src_o SHALL equal branch_i AND zero_i AND NOT stall_i, combinationally.
REQ-006 branch_target_o SHALL equal add_result_i, combinationally.
REQ-007 Data memory SHALL be 256 x 32-bit words, indexed by alu_result_i[9:2]; bits [31:10] SHALL be ignored, so addresses wrap modulo 1024 bytes.
REQ-008 Stores SHALL write read_data2_i on the rising clk edge when mem_write_i=1, stall_i=0 and no fault is present.
REQ-009 Loads SHALL read combinationally, with the value captured into mem_data_o on the same edge, for a total latency of one cycle from input to mem_data_o.
REQ-010 A fault SHALL exist when (mem_read_i OR mem_write_i) and alu_result_i[1:0] is not 00, or when mem_read_i and mem_write_i are both 1.
REQ-011 On a fault, the store SHALL be suppressed, mem_data_o SHALL capture 0, wb_o SHALL capture 00, and fault_o SHALL capture 1.
REQ-012 Without a fault, fault_o SHALL capture 0.
REQ-013 When stall_i=0, the MEM/WB register SHALL capture on each rising edge: mem_data_o (the load value, or 0 if mem_read_i=0), alu_result_o from alu_result_i, rd_or_rt_o from rd_or_rt_i, wb_o from wb_i, and fault_o.
REQ-014 When stall_i=1, every registered output SHALL hold its value and no memory write SHALL occur.
REQ-015 A load from the same word as the immediately preceding store SHALL return the newly written data.
REQ-016 A load or store at byte address 0x3FC SHALL access word 255; at 0x400 it SHALL access word 0.

Reset
REQ-017 Asserting rst SHALL immediately clear mem_data_o, alu_result_o, rd_or_rt_o, wb_o and fault_o to 0, independent of clk.
REQ-018 Memory contents SHALL NOT be affected by rst, and SHALL be zero at time zero in simulation.
REQ-019 A store present on the inputs while rst is asserted SHALL NOT write memory.
REQ-020 The first capturing edge after rst deasserts SHALL behave per REQ-013.

Structure
REQ-021 A shared package mips_pkg SHALL hold WB_REGWRITE=1, WB_MEMTOREG=0, DMEM_DEPTH=256 and DMEM_AW=8.
REQ-022 The memory array SHALL be a sub-module named data_mem, with ports clk, we, addr[7:0], wdata[32] and rdata[32] (asynchronous read).
REQ-023 Fault detection, branch logic and the MEM/WB register SHALL reside in mem_stage.

Verification
REQ-024 Store then load: store 0xDEADBEEF at address 0x10, then load 0x10 on the next cycle -> mem_data_o=0xDEADBEEF one cycle later, wb_o=11.
REQ-025 Branch: branch_i=1, zero_i=1, add_result_i=0x40 -> pc_src_o=1, branch_target_o=0x40; the same inputs with stall_i=1 -> pc_src_o=0.
REQ-026 Misaligned store: store to 0x13 -> fault_o=1 for one cycle, wb_o=00; a subsequent load of 0x10 returns the prior contents unchanged.
REQ-027 Wrap: store 0x1234 at 0x400, then load 0x000 -> 0x1234; store at 0x3FC, then load 0x7FC -> same data.
REQ-028 Stall: with stall_i=1 for 3 cycles while a store of 0xAA to 0x20 is applied -> outputs frozen and a load of 0x20 afterwards returns 0.
REQ-029 Reset mid-stream: assert rst asynchronously between edges while wb_o=10 -> all registered outputs go to 0 before the next edge, and memory retains earlier stores.
